step_sequencer: RTL and testbench

- Control block that drives an ODE iteration loop: loads a step count, then issues one step request per iteration to the solver datapath over a valid/ready handshake.
- Waits for the datapath's completion strobe before issuing the next step, counts down the remaining steps, and signals loop completion.
- Sits between the top-level controller (start/abort) and the per-step datapath.
- Counterpart to the down-counting iteration counters: this block generates the load and decrement events and consumes the terminal count.

---
 rtl/step_sequencer.sv | 129 ++++++++++++
 tb/tb_step_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: drives an ODE iteration loop. Loads a step count on start,
// issues one step request per iteration over a valid/ready handshake, waits
// for the datapath completion strobe, and reports normal completion (done)
// or termination (aborted) with single-cycle pulses.
//
// state  | meaning
// IDLE   | no loop active; waiting for start
// ISSUE  | step request presented (step_valid_o=1) until accepted
// WAIT   | request accepted; waiting for step_done_i
// FINISH | loop complete; done_o high for this one cycle
module step_sequencer #(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [WORD_SIZE-1:0] num_steps_i,
    input  logic                 abort_i,
    output logic                 step_valid_o,
    input  logic                 step_ready_i,
    output logic [WORD_SIZE-1:0] step_index_o,
    output logic                 step_last_o,
    input  logic                 step_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] remaining_q;
    logic [WORD_SIZE-1:0] step_index_q;
    logic                 step_last_q;
    logic                 step_valid_q;
    logic                 done_q;
    logic                 aborted_q;

    logic [WORD_SIZE-1:0] remaining_d;
    logic [WORD_SIZE-1:0] step_index_d;
    logic                 step_last_d;

    // Values loaded when advancing from one step to the next.
    always_comb begin
        remaining_d  = remaining_q - WORD_SIZE'(1);
        step_index_d = step_index_q + WORD_SIZE'(1);
        step_last_d  = (remaining_q == WORD_SIZE'(2));
    end

    // Sequencer FSM; every output except busy is a register updated here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            step_index_q <= '0;
            step_last_q  <= 1'b0;
            step_valid_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (num_steps_i != '0) begin
                            remaining_q  <= num_steps_i;
                            step_index_q <= '0;
                            step_last_q  <= (num_steps_i == WORD_SIZE'(1));
                            step_valid_q <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort_i) begin
                        step_valid_q <= 1'b0;
                        aborted_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (step_valid_q && step_ready_i) begin
                        step_valid_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort_i) begin
                        step_valid_q <= 1'b0;
                        aborted_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (step_done_i) begin
                        if (remaining_q == WORD_SIZE'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            remaining_q  <= remaining_d;
                            step_index_q <= step_index_d;
                            step_last_q  <= step_last_d;
                            step_valid_q <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    step_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign step_valid_o = step_valid_q;
    assign step_index_o = step_index_q;
    assign step_last_o  = step_last_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: stimulus pushes expected handshakes
// and completion events; a negedge monitor pops and compares them.
module tb_step_sequencer;

    localparam int WS = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [WS-1:0] num_steps = '0;
    logic          abort = 1'b0;
    logic          step_ready = 1'b0;
    logic          step_done = 1'b0;
    logic          step_valid;
    logic [WS-1:0] step_index;
    logic          step_last;
    logic          busy;
    logic          done;
    logic          aborted;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;

    // expected handshake: {last, index}; expected completion: 0=done, 1=aborted
    logic [WS:0] exp_step_q[$];
    int          exp_evt_q[$];
    logic [WS:0] mon_e;
    int          mon_ev;

    step_sequencer #(.WORD_SIZE(WS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .num_steps_i  (num_steps),
        .abort_i      (abort),
        .step_valid_o (step_valid),
        .step_ready_i (step_ready),
        .step_index_o (step_index),
        .step_last_o  (step_last),
        .step_done_i  (step_done),
        .busy_o       (busy),
        .done_o       (done),
        .aborted_o    (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [WS-1:0] n);
        start     = 1'b1;
        num_steps = n;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic push_step(input logic last, input logic [WS-1:0] idx);
        exp_step_q.push_back({last, idx});
    endtask

    // Monitor: handshakes and completion pulses against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (step_valid && step_ready) begin
                hs_count++;
                check("hs_expected", 64'(exp_step_q.size() != 0), 64'd1);
                if (exp_step_q.size() != 0) begin
                    mon_e = exp_step_q.pop_front();
                    check("hs_index", 64'(step_index), 64'(mon_e[WS-1:0]));
                    check("hs_last", 64'(step_last), 64'(mon_e[WS]));
                end
            end
            if (done || aborted) begin
                check("done_aborted_exclusive", 64'(done && aborted), 64'd0);
                check("completion_expected", 64'(exp_evt_q.size() != 0), 64'd1);
                if (exp_evt_q.size() != 0) begin
                    mon_ev = exp_evt_q.pop_front();
                    check("completion_kind", 64'(aborted), 64'(mon_ev));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        tick(2);
        check("rst_valid", 64'(step_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_index", 64'(step_index), 64'd0);
        check("rst_last", 64'(step_last), 64'd0);
        #2 rst_n = 1'b1;
        tick(1);

        // T1: three steps, ready and done held high; done in cycle 8
        step_ready = 1'b1;
        step_done  = 1'b1;
        push_step(1'b0, 0);
        push_step(1'b0, 1);
        push_step(1'b1, 2);
        exp_evt_q.push_back(0);
        do_start(3);
        for (int c = 2; c <= 8; c++) begin
            check($sformatf("t1_done_cycle%0d", c), 64'(done), 64'(c == 8));
            check($sformatf("t1_busy_cycle%0d", c), 64'(busy), 64'd1);
            tick(1);
        end
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_done_after", 64'(done), 64'd0);
        step_ready = 1'b0;
        step_done  = 1'b0;

        // T2: two steps, ready held off for four cycles
        push_step(1'b0, 0);
        push_step(1'b1, 1);
        exp_evt_q.push_back(0);
        do_start(2);
        for (int i = 0; i < 4; i++) begin
            check("t2_valid_held", 64'(step_valid), 64'd1);
            check("t2_index_stable", 64'(step_index), 64'd0);
            tick(1);
        end
        step_ready = 1'b1;
        tick(1);
        step_ready = 1'b0;
        check("t2_valid_after_hs", 64'(step_valid), 64'd0);
        tick(2);
        step_done = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t2_valid_step1", 64'(step_valid), 64'd1);
        check("t2_index_step1", 64'(step_index), 64'd1);
        check("t2_last_step1", 64'(step_last), 64'd1);
        step_ready = 1'b1;
        tick(1);
        step_ready = 1'b0;
        step_done  = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t2_done", 64'(done), 64'd1);
        tick(1);
        check("t2_busy_after", 64'(busy), 64'd0);

        // T3: zero steps
        exp_evt_q.push_back(0);
        do_start(0);
        check("t3_valid", 64'(step_valid), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_done", 64'(done), 64'd1);
        tick(1);
        check("t3_busy_after", 64'(busy), 64'd0);
        check("t3_done_after", 64'(done), 64'd0);

        // T4: abort in WAIT of second step together with step_done
        push_step(1'b0, 0);
        push_step(1'b0, 1);
        exp_evt_q.push_back(1);
        step_ready = 1'b1;
        do_start(5);
        tick(1);
        step_done = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t4_index_step1", 64'(step_index), 64'd1);
        tick(1);
        abort     = 1'b1;
        step_done = 1'b1;
        tick(1);
        abort     = 1'b0;
        step_done = 1'b0;
        check("t4_aborted", 64'(aborted), 64'd1);
        check("t4_done", 64'(done), 64'd0);
        check("t4_valid", 64'(step_valid), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        tick(1);
        check("t4_aborted_pulse", 64'(aborted), 64'd0);
        push_step(1'b1, 0);
        exp_evt_q.push_back(0);
        step_done = 1'b1;
        do_start(1);
        check("t4_restart_index", 64'(step_index), 64'd0);
        check("t4_restart_last", 64'(step_last), 64'd1);
        tick(2);
        check("t4_restart_done", 64'(done), 64'd1);
        tick(1);
        step_ready = 1'b0;
        step_done  = 1'b0;

        // T5: asynchronous reset while issuing the second step
        push_step(1'b0, 0);
        step_ready = 1'b1;
        do_start(4);
        tick(1);
        step_ready = 1'b0;
        step_done  = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t5_index_before_rst", 64'(step_index), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(step_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_index", 64'(step_index), 64'd0);
        check("t5_rst_aborted", 64'(aborted), 64'd0);
        #3 rst_n = 1'b1;
        tick(1);
        push_step(1'b1, 0);
        exp_evt_q.push_back(0);
        step_ready = 1'b1;
        step_done  = 1'b1;
        do_start(1);
        check("t5_restart_valid", 64'(step_valid), 64'd1);
        tick(2);
        check("t5_restart_done", 64'(done), 64'd1);
        tick(1);
        step_ready = 1'b0;
        step_done  = 1'b0;

        // T6: step_done during ISSUE and start during WAIT are ignored
        push_step(1'b0, 0);
        push_step(1'b1, 1);
        exp_evt_q.push_back(0);
        do_start(2);
        step_done = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t6_valid_after_done_in_issue", 64'(step_valid), 64'd1);
        check("t6_index_after_done_in_issue", 64'(step_index), 64'd0);
        step_ready = 1'b1;
        tick(1);
        step_ready = 1'b0;
        start      = 1'b1;
        num_steps  = 7;
        tick(1);
        start = 1'b0;
        check("t6_busy_start_in_wait", 64'(busy), 64'd1);
        check("t6_valid_start_in_wait", 64'(step_valid), 64'd0);
        check("t6_index_start_in_wait", 64'(step_index), 64'd0);
        step_done = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t6_index_step1", 64'(step_index), 64'd1);
        check("t6_last_step1", 64'(step_last), 64'd1);
        step_ready = 1'b1;
        tick(1);
        step_ready = 1'b0;
        step_done  = 1'b1;
        tick(1);
        step_done = 1'b0;
        check("t6_done", 64'(done), 64'd1);
        tick(2);

        check("steps_left", 64'(exp_step_q.size()), 64'd0);
        check("events_left", 64'(exp_evt_q.size()), 64'd0);
        check("hs_total", 64'(hs_count), 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
